// File: rtl/ast_rr_pkt_scheduler.sv
// Packet-aware round-robin scheduler: DIRS_CNT Avalon-ST sinks share one
// registered Avalon-ST source; a grant is held from SOP through EOP.
//
// Ports:
//   clk_i, rst_n_i          clock, async active-low reset
//   ast_sink_*_i            per-channel data/valid/sop/eop (channel k at
//                           data[k*DATA_W +: DATA_W])
//   ast_sink_ready_o        per-channel ready, at most one bit set
//   ast_source_*_o          registered output beat
//   ast_source_ready_i      downstream ready
//   grant_num_o             channel currently/last granted
//   busy_o                  high while a packet grant is held
//   sop_err_o               1-cycle pulse on a misplaced or missing sop
module ast_rr_pkt_scheduler #(
    parameter  int DIRS_CNT    = 4,
    parameter  int AST_SYMBOLS = 1,
    parameter  int BYTE_W      = 8,
    localparam int DATA_W      = AST_SYMBOLS * BYTE_W,
    localparam int SEL_W       = $clog2(DIRS_CNT)
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [DIRS_CNT*DATA_W-1:0]   ast_sink_data_i,
    input  logic [DIRS_CNT-1:0]          ast_sink_valid_i,
    input  logic [DIRS_CNT-1:0]          ast_sink_sop_i,
    input  logic [DIRS_CNT-1:0]          ast_sink_eop_i,
    output logic [DIRS_CNT-1:0]          ast_sink_ready_o,
    output logic [DATA_W-1:0]            ast_source_data_o,
    output logic                         ast_source_valid_o,
    output logic                         ast_source_sop_o,
    output logic                         ast_source_eop_o,
    input  logic                         ast_source_ready_i,
    output logic [SEL_W-1:0]             grant_num_o,
    output logic                         busy_o,
    output logic                         sop_err_o
);

    typedef enum logic {
        IDLE,
        PKT
    } state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]    grant_q, grant_d;
    logic                first_q, first_d;
    logic [DATA_W-1:0]   src_data_q, src_data_d;
    logic                src_valid_q, src_valid_d;
    logic                src_sop_q, src_sop_d;
    logic                src_eop_q, src_eop_d;
    logic                err_q, err_d;

    logic                out_free;
    logic                accept;
    logic [DATA_W-1:0]   beat_data;
    logic                beat_sop;
    logic                beat_eop;
    logic                win_found;
    logic [SEL_W-1:0]    win_idx;
    logic [SEL_W-1:0]    k;
    logic [DIRS_CNT-1:0] sink_ready;

    assign out_free  = !src_valid_q || ast_source_ready_i;
    assign beat_data = ast_sink_data_i[grant_q*DATA_W +: DATA_W];
    assign beat_sop  = ast_sink_sop_i[grant_q];
    assign beat_eop  = ast_sink_eop_i[grant_q];
    assign accept    = (state_q == PKT) && ast_sink_valid_i[grant_q]
                       && out_free;

    // Search starts just after the last packet's owner, so that owner
    // has the lowest priority for the next grant.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        k         = '0;
        for (int i = 1; i <= DIRS_CNT; i++) begin
            k = SEL_W'((int'(rr_ptr_q) + i) % DIRS_CNT);
            if (!win_found && ast_sink_valid_i[k]) begin
                win_found = 1'b1;
                win_idx   = k;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        first_d     = first_q;
        src_data_d  = src_data_q;
        src_valid_d = src_valid_q;
        src_sop_d   = src_sop_q;
        src_eop_d   = src_eop_q;
        err_d       = 1'b0;
        sink_ready  = '0;

        // Output slot drains when it is empty or being consumed.
        if (out_free) begin
            src_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d = win_idx;
                    first_d = 1'b1;
                    state_d = PKT;
                end
            end
            PKT: begin
                sink_ready[grant_q] = out_free;
                if (accept) begin
                    src_data_d  = beat_data;
                    src_valid_d = 1'b1;
                    src_sop_d   = beat_sop;
                    src_eop_d   = beat_eop;
                    err_d       = first_q ? !beat_sop : beat_sop;
                    first_d     = 1'b0;
                    if (beat_eop) begin
                        state_d  = IDLE;
                        rr_ptr_d = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= SEL_W'(DIRS_CNT - 1);
            grant_q     <= '0;
            first_q     <= 1'b0;
            src_data_q  <= '0;
            src_valid_q <= 1'b0;
            src_sop_q   <= 1'b0;
            src_eop_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            first_q     <= first_d;
            src_data_q  <= src_data_d;
            src_valid_q <= src_valid_d;
            src_sop_q   <= src_sop_d;
            src_eop_q   <= src_eop_d;
            err_q       <= err_d;
        end
    end

    assign ast_sink_ready_o   = sink_ready;
    assign ast_source_data_o  = src_data_q;
    assign ast_source_valid_o = src_valid_q;
    assign ast_source_sop_o   = src_sop_q;
    assign ast_source_eop_o   = src_eop_q;
    assign grant_num_o        = grant_q;
    assign busy_o             = (state_q == PKT);
    assign sop_err_o          = err_q;

endmodule

// File: tb/tb_ast_rr_pkt_scheduler.sv
// Testbench for ast_rr_pkt_scheduler: directed scenarios plus randomized
// traffic, every cycle compared against a behavioural reference model.
module tb_ast_rr_pkt_scheduler;

    logic        clk;
    logic        rst_n;
    logic [31:0] data;
    logic [3:0]  v;
    logic [3:0]  sop;
    logic [3:0]  eop;
    logic [3:0]  rdy;
    logic [7:0]  odata;
    logic        ovalid;
    logic        osop;
    logic        oeop;
    logic        srdy;
    logic [1:0]  gnt;
    logic        busy;
    logic        err;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit          m_busy;
    int          m_gnt;
    int          m_ptr;
    bit          m_first;
    bit          m_ov;
    bit          m_os;
    bit          m_oe;
    bit          m_err;
    logic [7:0]  m_od;

    ast_rr_pkt_scheduler #(
        .DIRS_CNT    (4),
        .AST_SYMBOLS (1),
        .BYTE_W      (8)
    ) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .ast_sink_data_i    (data),
        .ast_sink_valid_i   (v),
        .ast_sink_sop_i     (sop),
        .ast_sink_eop_i     (eop),
        .ast_sink_ready_o   (rdy),
        .ast_source_data_o  (odata),
        .ast_source_valid_o (ovalid),
        .ast_source_sop_o   (osop),
        .ast_source_eop_o   (oeop),
        .ast_source_ready_i (srdy),
        .grant_num_o        (gnt),
        .busy_o             (busy),
        .sop_err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_gnt   = 0;
        m_ptr   = 3;
        m_first = 0;
        m_ov    = 0;
        m_os    = 0;
        m_oe    = 0;
        m_err   = 0;
        m_od    = '0;
    endtask

    // One clock cycle: inputs are already driven (just after a negedge).
    task automatic cyc();
        bit         free;
        bit         found;
        int         c;
        logic [3:0] er;
        bit         n_busy, n_first, n_ov, n_os, n_oe, n_err;
        int         n_gnt, n_ptr;
        logic [7:0] n_od;
        #1;
        free = !m_ov || srdy;
        er   = (m_busy && free) ? 4'(1 << m_gnt) : 4'b0;
        chk("ready", 32'(rdy), 32'(er));
        chk("valid", 32'(ovalid), 32'(m_ov));
        if (m_ov) begin
            chk("data", 32'(odata), 32'(m_od));
            chk("sop", 32'(osop), 32'(m_os));
            chk("eop", 32'(oeop), 32'(m_oe));
        end
        chk("grant", 32'(gnt), 32'(m_gnt));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("sop_err", 32'(err), 32'(m_err));

        n_busy  = m_busy;
        n_first = m_first;
        n_gnt   = m_gnt;
        n_ptr   = m_ptr;
        n_ov    = free ? 1'b0 : m_ov;
        n_os    = m_os;
        n_oe    = m_oe;
        n_od    = m_od;
        n_err   = 0;
        if (!m_busy) begin
            found = 0;
            for (int i = 1; i <= 4; i++) begin
                c = (m_ptr + i) % 4;
                if (!found && v[c]) begin
                    found   = 1;
                    n_gnt   = c;
                    n_busy  = 1;
                    n_first = 1;
                end
            end
        end else if (v[m_gnt] && free) begin
            n_ov    = 1;
            n_od    = data[m_gnt*8 +: 8];
            n_os    = sop[m_gnt];
            n_oe    = eop[m_gnt];
            n_err   = m_first ? !sop[m_gnt] : sop[m_gnt];
            n_first = 0;
            if (eop[m_gnt]) begin
                n_busy = 0;
                n_ptr  = m_gnt;
            end
        end
        @(posedge clk);
        m_busy  = n_busy;
        m_first = n_first;
        m_gnt   = n_gnt;
        m_ptr   = n_ptr;
        m_ov    = n_ov;
        m_os    = n_os;
        m_oe    = n_oe;
        m_od    = n_od;
        m_err   = n_err;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0;
        v     = '0;
        sop   = '0;
        eop   = '0;
        data  = '0;
        srdy  = 1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        v     = '0;
        sop   = '0;
        eop   = '0;
        data  = '0;
        srdy  = 1;

        // T1: 3-beat packet on ch2
        do_reset();
        #1;
        chk("rst_valid", 32'(ovalid), 32'd0);
        chk("rst_grant", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        v = 4'b0100; sop = 4'b0100; eop = 4'b0000; data = 32'h00A0_0000;
        #1;
        chk("t1_c0_rdy", 32'(rdy), 32'd0);
        cyc();
        #1;
        chk("t1_c1_rdy", 32'(rdy), 32'b0100);
        chk("t1_c1_gnt", 32'(gnt), 32'd2);
        cyc();
        sop = 4'b0000; data = 32'h00B0_0000;
        #1;
        chk("t1_c2_valid", 32'(ovalid), 32'd1);
        chk("t1_c2_data", 32'(odata), 32'hA0);
        chk("t1_c2_sop", 32'(osop), 32'd1);
        cyc();
        eop = 4'b0100; data = 32'h00C0_0000;
        #1;
        chk("t1_c3_data", 32'(odata), 32'hB0);
        chk("t1_c3_sop", 32'(osop), 32'd0);
        cyc();
        v = '0;
        #1;
        chk("t1_c4_data", 32'(odata), 32'hC0);
        chk("t1_c4_eop", 32'(oeop), 32'd1);
        chk("t1_c4_busy", 32'(busy), 32'd0);
        cyc();
        #1;
        chk("t1_c5_valid", 32'(ovalid), 32'd0);
        cyc();

        // T2: all channels stream 1-beat packets
        do_reset();
        v = 4'b1111; sop = 4'b1111; eop = 4'b1111; data = 32'h1312_1110;
        for (int c = 0; c <= 10; c++) begin
            #1;
            if (c >= 2 && (c % 2) == 0) begin
                chk("t2_valid", 32'(ovalid), 32'd1);
                chk("t2_order", 32'(odata), 32'h10 + 32'(((c - 2) / 2) % 4));
            end else if (c >= 3) begin
                chk("t2_bubble", 32'(ovalid), 32'd0);
            end
            cyc();
        end

        // T3: ch3 waits for ch1's packet to finish
        do_reset();
        v = 4'b0010; sop = 4'b0010; eop = 4'b0000; data = 32'h0000_2100;
        cyc();
        cyc();
        v = 4'b1010; sop = 4'b1000; eop = 4'b1000; data = 32'h3100_2200;
        #1;
        chk("t3_hold_gnt", 32'(gnt), 32'd1);
        chk("t3_hold_rdy", 32'(rdy), 32'b0010);
        cyc();
        eop = 4'b1010; data = 32'h3100_2300;
        cyc();
        v = 4'b1000;
        #1;
        chk("t3_idle_busy", 32'(busy), 32'd0);
        chk("t3_idle_rdy", 32'(rdy), 32'd0);
        cyc();
        #1;
        chk("t3_new_gnt", 32'(gnt), 32'd3);
        chk("t3_new_rdy", 32'(rdy), 32'b1000);
        cyc();
        v = '0;
        #1;
        chk("t3_out", 32'(odata), 32'h31);
        cyc();
        cyc();

        // T4: output stall mid-packet on ch0
        do_reset();
        v = 4'b0001; sop = 4'b0001; eop = 4'b0000; data = 32'h40;
        cyc();
        cyc();
        sop = 4'b0000; data = 32'h41;
        cyc();
        srdy = 0; data = 32'h42;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_stall_data", 32'(odata), 32'h41);
            chk("t4_stall_valid", 32'(ovalid), 32'd1);
            chk("t4_stall_rdy", 32'(rdy), 32'd0);
            cyc();
        end
        srdy = 1;
        #1;
        chk("t4_rel_data", 32'(odata), 32'h41);
        chk("t4_rel_rdy", 32'(rdy), 32'b0001);
        cyc();
        eop = 4'b0001; data = 32'h43;
        #1;
        chk("t4_next", 32'(odata), 32'h42);
        cyc();
        v = '0;
        #1;
        chk("t4_last", 32'(odata), 32'h43);
        chk("t4_last_eop", 32'(oeop), 32'd1);
        cyc();
        cyc();

        // T5: first beat of a grant without sop
        do_reset();
        v = 4'b0001; sop = 4'b0000; eop = 4'b0001; data = 32'h55;
        cyc();
        cyc();
        v = '0;
        #1;
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_data", 32'(odata), 32'h55);
        chk("t5_sop", 32'(osop), 32'd0);
        cyc();
        #1;
        chk("t5_err_gone", 32'(err), 32'd0);
        cyc();

        // T6: reset mid-packet on ch2
        do_reset();
        v = 4'b0100; sop = 4'b0100; eop = 4'b0000; data = 32'h0061_0000;
        cyc();
        cyc();
        sop = 4'b0000; data = 32'h0062_0000;
        cyc();
        rst_n = 0;
        #1;
        chk("t6_rdy", 32'(rdy), 32'd0);
        chk("t6_valid", 32'(ovalid), 32'd0);
        chk("t6_data", 32'(odata), 32'd0);
        chk("t6_sop", 32'(osop), 32'd0);
        chk("t6_eop", 32'(oeop), 32'd0);
        chk("t6_gnt", 32'(gnt), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_err", 32'(err), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        v = 4'b0101; sop = 4'b0101; eop = 4'b0101; data = 32'h0062_0070;
        cyc();
        #1;
        chk("t6_first_gnt", 32'(gnt), 32'd0);
        chk("t6_first_rdy", 32'(rdy), 32'b0001);
        cyc();
        cyc();

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 800; n++) begin
            v    = 4'($urandom);
            sop  = 4'($urandom);
            for (int b = 0; b < 4; b++) begin
                eop[b] = ($urandom_range(0, 9) < 4);
            end
            data = $urandom;
            srdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cyc();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
